// File: rtl/ul_frame_mux.sv
// Uplink framer: round-robin merges NUM_CH byte streams into framed 10-bit words
// (header, payload, checksum trailer). Frames are aborted on stall or link loss.
module ul_frame_mux #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned MAX_PAYLOAD = 64,
    parameter int unsigned STALL_LIMIT = 16,
    parameter logic [7:0]  IDLE_CODE   = 8'hBC
) (
    input  logic                Clk10MHz,
    input  logic                nRst,
    input  logic                LinkUp,
    input  logic [8*NUM_CH-1:0] ChData,
    input  logic [NUM_CH-1:0]   ChValid,
    input  logic [NUM_CH-1:0]   ChLast,
    output logic [NUM_CH-1:0]   ChReady,
    output logic [9:0]          DataOut,
    output logic                DataOutEn,
    output logic                FrameDone,
    output logic [7:0]          AbortCnt
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StHdr     = 2'd1;
    localparam logic [1:0] StPayload = 2'd2;
    localparam logic [1:0] StTrl     = 2'd3;

    logic [1:0]        r_state, w_state_nxt;
    logic [3:0]        r_grant, w_grant_nxt, r_rr, w_rr_nxt, w_arb, w_rr_adv;
    logic [NUM_CH-1:0] r_cont, w_cont_nxt;
    logic [7:0]        r_sum, w_sum_nxt, r_cnt, w_cnt_nxt, r_stall, w_stall_nxt;
    logic [7:0]        w_cnt_inc, w_stall_inc, w_byte, w_hdr;
    logic              r_abort, w_abort_nxt;
    logic [9:0]        r_data_out, w_out_nxt;
    logic              r_data_en, r_frame_done, w_done_nxt;
    logic [7:0]        r_abort_cnt, w_abort_cnt_nxt;
    logic              w_last, w_cont_g, w_hs, w_abort_inc, w_cont_wr, w_cont_val;

    assign DataOut   = r_data_out;
    assign DataOutEn = r_data_en;
    assign FrameDone = r_frame_done;
    assign AbortCnt  = r_abort_cnt;

    always_comb begin
        ChReady  = '0;
        w_byte   = '0;
        w_last   = 1'b0;
        w_cont_g = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            ChReady[i] = (r_state == StPayload) && LinkUp && (r_grant == 4'(i));
            if (r_grant == 4'(i)) begin
                w_byte   = ChData[8*i +: 8];
                w_last   = ChLast[i];
                w_cont_g = r_cont[i];
            end
        end
    end

    assign w_hs        = |(ChReady & ChValid);
    assign w_hdr       = {w_cont_g, 3'b000, r_grant};
    assign w_rr_adv    = (r_grant == 4'(NUM_CH - 1)) ? 4'd0 : r_grant + 4'd1;
    assign w_cnt_inc   = r_cnt + 8'd1;
    assign w_stall_inc = r_stall + 8'd1;

    // Highest offset first so the lowest offset from the pointer wins.
    always_comb begin
        w_arb = r_rr;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            for (int j = 0; j < NUM_CH; j++) begin
                if (ChValid[j] && ((int'(r_rr) + k) % int'(NUM_CH)) == j) w_arb = 4'(j);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_rr_nxt    = r_rr;
        w_sum_nxt   = r_sum;
        w_cnt_nxt   = r_cnt;
        w_stall_nxt = r_stall;
        w_abort_nxt = r_abort;
        w_out_nxt   = {2'b00, IDLE_CODE};
        w_done_nxt  = 1'b0;
        w_abort_inc = 1'b0;
        w_cont_wr   = 1'b0;
        w_cont_val  = 1'b0;
        if (!LinkUp) begin
            w_state_nxt = StIdle;
            if (r_state == StHdr || r_state == StPayload || (r_state == StTrl && r_abort)) begin
                w_abort_inc = 1'b1;
                w_cont_wr   = 1'b1;
            end
            if (r_state != StIdle) w_rr_nxt = w_rr_adv;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (|ChValid) begin
                        w_grant_nxt = w_arb;
                        w_cnt_nxt   = '0;
                        w_stall_nxt = '0;
                        w_abort_nxt = 1'b0;
                        w_state_nxt = StHdr;
                    end
                end
                StHdr: begin
                    w_out_nxt   = {2'b01, w_hdr};
                    w_sum_nxt   = w_hdr;
                    w_state_nxt = StPayload;
                end
                StPayload: begin
                    if (w_hs) begin
                        w_out_nxt   = {2'b10, w_byte};
                        w_sum_nxt   = r_sum + w_byte;
                        w_cnt_nxt   = w_cnt_inc;
                        w_stall_nxt = '0;
                        if (w_last) begin
                            w_cont_wr   = 1'b1;
                            w_state_nxt = StTrl;
                        end else if (w_cnt_inc == 8'(MAX_PAYLOAD)) begin
                            w_cont_wr   = 1'b1;
                            w_cont_val  = 1'b1;
                            w_state_nxt = StTrl;
                        end
                    end else begin
                        w_stall_nxt = w_stall_inc;
                        if (w_stall_inc == 8'(STALL_LIMIT)) begin
                            w_abort_nxt = 1'b1;
                            w_state_nxt = StTrl;
                        end
                    end
                end
                StTrl: begin
                    w_out_nxt   = {2'b11, r_abort ? ~r_sum : r_sum};
                    w_done_nxt  = 1'b1;
                    w_abort_inc = r_abort;
                    w_cont_wr   = r_abort;
                    w_rr_nxt    = w_rr_adv;
                    w_state_nxt = StIdle;
                end
                default: w_state_nxt = StIdle;
            endcase
        end
        w_cont_nxt = r_cont;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_cont_wr && r_grant == 4'(i)) w_cont_nxt[i] = w_cont_val;
        end
        w_abort_cnt_nxt = (w_abort_inc && r_abort_cnt != 8'hFF) ? r_abort_cnt + 8'd1
                                                                 : r_abort_cnt;
    end

    always_ff @(posedge Clk10MHz or negedge nRst) begin
        if (!nRst) begin
            r_state      <= StIdle;
            r_grant      <= '0;
            r_rr         <= '0;
            r_cont       <= '0;
            r_sum        <= '0;
            r_cnt        <= '0;
            r_stall      <= '0;
            r_abort      <= 1'b0;
            r_data_out   <= {2'b00, IDLE_CODE};
            r_data_en    <= 1'b0;
            r_frame_done <= 1'b0;
            r_abort_cnt  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_rr         <= w_rr_nxt;
            r_cont       <= w_cont_nxt;
            r_sum        <= w_sum_nxt;
            r_cnt        <= w_cnt_nxt;
            r_stall      <= w_stall_nxt;
            r_abort      <= w_abort_nxt;
            r_data_out   <= w_out_nxt;
            r_data_en    <= LinkUp;
            r_frame_done <= w_done_nxt;
            r_abort_cnt  <= w_abort_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_ul_frame_mux.sv
// Scoreboard bench for ul_frame_mux: stimulus queues expected non-idle words,
// a monitor pops and compares them along with fill counts and FrameDone.
module tb_ul_frame_mux;

    localparam int NCH = 4;

    typedef struct {
        logic [9:0] word;
        int         fills;
    } exp_t;

    logic             clk = 1'b0;
    logic             nRst = 1'b0;
    logic             LinkUp = 1'b0;
    logic [8*NCH-1:0] ChData;
    logic [NCH-1:0]   ChValid, ChLast, ChReady;
    logic [9:0]       DataOut;
    logic             DataOutEn, FrameDone;
    logic [7:0]       AbortCnt;

    logic [7:0] tb_data  [NCH];
    logic       tb_valid [NCH];
    logic       tb_last  [NCH];

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   fill_cnt = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            ChData[8*i +: 8] = tb_data[i];
            ChValid[i]       = tb_valid[i];
            ChLast[i]        = tb_last[i];
        end
    end

    ul_frame_mux #(
        .NUM_CH      (NCH),
        .MAX_PAYLOAD (4),
        .STALL_LIMIT (16),
        .IDLE_CODE   (8'hBC)
    ) dut (
        .Clk10MHz  (clk),
        .nRst      (nRst),
        .LinkUp    (LinkUp),
        .ChData    (ChData),
        .ChValid   (ChValid),
        .ChLast    (ChLast),
        .ChReady   (ChReady),
        .DataOut   (DataOut),
        .DataOutEn (DataOutEn),
        .FrameDone (FrameDone),
        .AbortCnt  (AbortCnt)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic push(input logic [9:0] w, input int f);
        exp_t e;
        e.word  = w;
        e.fills = f;
        q.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the byte was accepted.
    task automatic send_byte(input logic [1:0] ch, input logic [7:0] d, input logic last);
        int n = 0;
        tb_data[ch]  = d;
        tb_last[ch]  = last;
        tb_valid[ch] = 1'b1;
        while (ChReady[ch] !== 1'b1) begin
            @(negedge clk);
            n++;
            if (n > 300) begin
                n_checks++;
                n_errors++;
                $display("FAIL send_timeout: ch %0d byte 0x%0h waited %0d cycles, limit 300",
                         ch, d, n);
                tb_valid[ch] = 1'b0;
                return;
            end
        end
        @(negedge clk);
        tb_valid[ch] = 1'b0;
        tb_last[ch]  = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("queue_drained", 32'(q.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!nRst || !DataOutEn) begin
                fill_cnt = 0;
            end else if (DataOut[9:8] == 2'b00) begin
                fill_cnt++;
                check("idle_byte", 32'(DataOut[7:0]), 32'h0BC);
                check("idle_frame_done", 32'(FrameDone), 32'd0);
            end else begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_word: got 0x%0h, expected no word", DataOut);
                end else begin
                    e = q.pop_front();
                    check("word", 32'(DataOut), 32'(e.word));
                    if (e.fills >= 0) check("fills_before_word", 32'(fill_cnt), 32'(e.fills));
                end
                check("frame_done", 32'(FrameDone), 32'(DataOut[9:8] == 2'b11));
                fill_cnt = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < NCH; i++) begin
            tb_data[i]  = 8'h00;
            tb_valid[i] = 1'b0;
            tb_last[i]  = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("rst_dataout", 32'(DataOut), 32'h0BC);
        check("rst_en", 32'(DataOutEn), 32'd0);
        check("rst_done", 32'(FrameDone), 32'd0);
        check("rst_abortcnt", 32'(AbortCnt), 32'd0);
        check("rst_ready", 32'(ChReady), 32'd0);
        nRst   = 1'b1;
        LinkUp = 1'b1;
        @(negedge clk);

        // Round robin, all channels valid with 1-byte messages
        push(10'h100, -1); push(10'h210, 0); push(10'h310, 0);
        push(10'h101, 1);  push(10'h221, 0); push(10'h322, 0);
        push(10'h102, 1);  push(10'h232, 0); push(10'h334, 0);
        push(10'h103, 1);  push(10'h243, 0); push(10'h346, 0);
        push(10'h100, 1);  push(10'h250, 0); push(10'h350, 0);
        fork
            begin send_byte(2'd0, 8'h10, 1'b1); send_byte(2'd0, 8'h50, 1'b1); end
            send_byte(2'd1, 8'h21, 1'b1);
            send_byte(2'd2, 8'h32, 1'b1);
            send_byte(2'd3, 8'h43, 1'b1);
        join
        wait_drain();

        // ch2 three-byte message
        push(10'h102, -1); push(10'h211, 0); push(10'h222, 0); push(10'h233, 0);
        push(10'h368, 0);
        send_byte(2'd2, 8'h11, 1'b0);
        send_byte(2'd2, 8'h22, 1'b0);
        send_byte(2'd2, 8'h33, 1'b1);
        wait_drain();

        // ch1 six-byte message split at MAX_PAYLOAD=4
        push(10'h101, -1); push(10'h2A1, 0); push(10'h2A2, 0); push(10'h2A3, 0);
        push(10'h2A4, 0);  push(10'h38B, 0);
        push(10'h181, 1);  push(10'h2A5, 0); push(10'h2A6, 0); push(10'h3CC, 0);
        for (int b = 1; b <= 6; b++) send_byte(2'd1, 8'(8'hA0 + b), 1'(b == 6));
        wait_drain();

        // Stall abort after one byte
        push(10'h100, -1); push(10'h237, 0); push(10'h3C8, 16);
        send_byte(2'd0, 8'h37, 1'b0);
        wait_drain();
        check("stall_abortcnt", 32'(AbortCnt), 32'd1);

        // Link drop mid payload
        push(10'h103, -1); push(10'h244, 0);
        send_byte(2'd3, 8'h44, 1'b0);
        wait_drain();
        LinkUp = 1'b0;
        tb_data[3] = 8'h06; tb_last[3] = 1'b1; tb_valid[3] = 1'b1;
        tb_data[0] = 8'h05; tb_last[0] = 1'b1; tb_valid[0] = 1'b1;
        #1;
        check("linkdown_ready_now", 32'(ChReady), 32'd0);
        @(negedge clk);
        check("linkdown_en", 32'(DataOutEn), 32'd0);
        check("linkdown_ready", 32'(ChReady), 32'd0);
        check("linkdown_abortcnt", 32'(AbortCnt), 32'd2);
        @(negedge clk);
        push(10'h100, -1); push(10'h205, 0); push(10'h305, 0);
        push(10'h103, 1);  push(10'h206, 0); push(10'h309, 0);
        LinkUp = 1'b1;
        fork
            send_byte(2'd0, 8'h05, 1'b1);
            send_byte(2'd3, 8'h06, 1'b1);
        join
        wait_drain();

        // Asynchronous reset mid frame
        push(10'h101, -1); push(10'h255, 0);
        send_byte(2'd1, 8'h55, 1'b0);
        wait_drain();
        #2 nRst = 1'b0;
        #1;
        check("midrst_dataout", 32'(DataOut), 32'h0BC);
        check("midrst_en", 32'(DataOutEn), 32'd0);
        check("midrst_done", 32'(FrameDone), 32'd0);
        check("midrst_abortcnt", 32'(AbortCnt), 32'd0);
        check("midrst_ready", 32'(ChReady), 32'd0);
        @(negedge clk);
        nRst = 1'b1;

        // AbortCnt saturation: drop the link while each frame is in its header state
        tb_data[0] = 8'h00; tb_last[0] = 1'b1; tb_valid[0] = 1'b1;
        for (int i = 0; i < 254; i++) begin
            LinkUp = 1'b1;
            @(negedge clk);
            LinkUp = 1'b0;
            @(negedge clk);
        end
        check("abortcnt_254", 32'(AbortCnt), 32'd254);
        for (int i = 0; i < 46; i++) begin
            LinkUp = 1'b1;
            @(negedge clk);
            LinkUp = 1'b0;
            @(negedge clk);
        end
        check("abortcnt_sat", 32'(AbortCnt), 32'd255);
        tb_valid[0] = 1'b0;
        LinkUp = 1'b1;
        repeat (4) @(negedge clk);
        check("final_queue_empty", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
